// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge.
// Contents used by the read data FIFO:
//   TAG_NUM, TAG_W, AXI_DATA_W : transaction tag space and AXI data width
//   RDF_DEPTH_PER_TAG          : beats buffered per tag (AXI3 max burst)
//   RDF_CNT_W                  : occupancy counter width (one bit wider than a pointer)
//   rdf_entry_t                : one buffered read beat {tag, data, last, resp}
package apb2axi_pkg;

  localparam int TAG_NUM           = 8;
  localparam int TAG_W             = 3;
  localparam int AXI_DATA_W        = 32;
  localparam int RDF_DEPTH_PER_TAG = 16;
  localparam int RDF_CNT_W         = $clog2(RDF_DEPTH_PER_TAG) + 1;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [AXI_DATA_W-1:0] data;
    logic                  last;
    logic [1:0]            resp;
  } rdf_entry_t;

endpackage

// File: rtl/apb2axi_rdf_seg.sv
// Single-tag circular buffer segment of the read data FIFO.
// Ports:
//   aclk, areset   : clock, asynchronous active-high reset
//   push_i         : store push_entry_i (dropped when full or when flushing)
//   push_entry_i   : beat to store
//   pop_i          : remove the head beat (ignored when empty)
//   flush_i        : discard all stored beats at the next edge
//   pop_entry_o    : head beat captured on an accepted pop (registered read)
//   cnt_o          : current occupancy
//   done_o         : a beat with last=1 is stored and not yet popped
//   ovf_o          : this cycle's push is being dropped because the segment is full
//   empty_o        : occupancy is zero
module apb2axi_rdf_seg
  import apb2axi_pkg::*;
#(
  parameter int DEPTH = RDF_DEPTH_PER_TAG
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       push_i,
  input  rdf_entry_t                 push_entry_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output rdf_entry_t                 pop_entry_o,
  output logic [$clog2(DEPTH):0]     cnt_o,
  output logic                       done_o,
  output logic                       ovf_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rdf_entry_t       mem_q [DEPTH];
  rdf_entry_t       pop_entry_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic full;
  logic push_acc;
  logic pop_acc;
  logic head_last;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  // Full is judged on the pre-pop count, so a same-cycle pop never makes room.
  assign push_acc  = push_i & ~flush_i & ~full;
  assign pop_acc   = pop_i & ~empty_o;
  // A push discarded by a flush is intentional, not an overflow.
  assign ovf_o     = push_i & ~flush_i & full;
  assign head_last = mem_q[rd_ptr_q].last;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      done_d   = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
      // A newly completed burst outranks the retirement of an older one.
      if (push_acc && push_entry_i.last)  done_d = 1'b1;
      else if (pop_acc && head_last)      done_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // Storage is not reset; the pop read uses the pre-flush pointer so a pop
  // issued alongside a flush still returns the old head beat.
  always_ff @(posedge aclk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_entry_i;
    if (pop_acc)  pop_entry_q     <= mem_q[rd_ptr_q];
  end

  assign pop_entry_o = pop_entry_q;
  assign cnt_o       = cnt_q;
  assign done_o      = done_q;

endmodule

// File: rtl/apb2axi_rdf.sv
// Read data FIFO: buffers AXI read beats per tag for APB-side readout.
// Ports:
//   aclk, areset                  : clock, asynchronous active-high reset
//   rsp_rdf_push_vld/_payload     : beat from the response collector
//   rsp_rdf_push_rdy              : every segment has room for the reserved in-flight beat
//   rdf_pop_req/_tag              : pop one beat of a tag
//   rdf_pop_vld/_payload/_empty   : pop result, one cycle after the request
//   rdf_flush/_tag                : discard one tag's segment
//   rdf_tag_done                  : per-tag "whole burst buffered" bitmap
//   rdf_tag_cnt_sel/rdf_tag_cnt   : occupancy readback of the selected tag
//   rdf_err_ovf                   : sticky push-into-full-segment error
module apb2axi_rdf
  import apb2axi_pkg::*;
#(
  parameter int DEPTH_PER_TAG = RDF_DEPTH_PER_TAG
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             rsp_rdf_push_vld,
  input  rdf_entry_t                       rsp_rdf_push_payload,
  output logic                             rsp_rdf_push_rdy,
  input  logic                             rdf_pop_req,
  input  logic [TAG_W-1:0]                 rdf_pop_tag,
  output logic                             rdf_pop_vld,
  output rdf_entry_t                       rdf_pop_payload,
  output logic                             rdf_pop_empty,
  input  logic                             rdf_flush,
  input  logic [TAG_W-1:0]                 rdf_flush_tag,
  output logic [TAG_NUM-1:0]               rdf_tag_done,
  input  logic [TAG_W-1:0]                 rdf_tag_cnt_sel,
  output logic [$clog2(DEPTH_PER_TAG):0]   rdf_tag_cnt,
  output logic                             rdf_err_ovf
);

  localparam int CNT_W = $clog2(DEPTH_PER_TAG) + 1;

  rdf_entry_t         seg_pop_entry [TAG_NUM];
  logic [CNT_W-1:0]   seg_cnt       [TAG_NUM];
  logic [TAG_NUM-1:0] seg_done;
  logic [TAG_NUM-1:0] seg_ovf;
  logic [TAG_NUM-1:0] seg_empty;
  logic [TAG_NUM-1:0] seg_room;

  logic             pop_vld_q;
  logic             pop_empty_q;
  logic [TAG_W-1:0] pop_tag_q;
  logic             err_q;

  genvar gi;
  generate
    for (gi = 0; gi < TAG_NUM; gi++) begin : g_seg
      logic push_sel, pop_sel, flush_sel;
      assign push_sel  = rsp_rdf_push_vld && (rsp_rdf_push_payload.tag == TAG_W'(gi));
      assign pop_sel   = rdf_pop_req && (rdf_pop_tag == TAG_W'(gi));
      assign flush_sel = rdf_flush && (rdf_flush_tag == TAG_W'(gi));
      // One slot stays free for the beat the collector may already have in flight.
      assign seg_room[gi] = (seg_cnt[gi] <= CNT_W'(DEPTH_PER_TAG - 2));

      apb2axi_rdf_seg #(.DEPTH(DEPTH_PER_TAG)) u_seg (
        .aclk         (aclk),
        .areset       (areset),
        .push_i       (push_sel),
        .push_entry_i (rsp_rdf_push_payload),
        .pop_i        (pop_sel),
        .flush_i      (flush_sel),
        .pop_entry_o  (seg_pop_entry[gi]),
        .cnt_o        (seg_cnt[gi]),
        .done_o       (seg_done[gi]),
        .ovf_o        (seg_ovf[gi]),
        .empty_o      (seg_empty[gi])
      );
    end
  endgenerate

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pop_vld_q   <= 1'b0;
      pop_empty_q <= 1'b0;
      pop_tag_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      pop_vld_q   <= rdf_pop_req;
      pop_empty_q <= rdf_pop_req & seg_empty[rdf_pop_tag];
      pop_tag_q   <= rdf_pop_tag;
      err_q       <= err_q | (|seg_ovf);
    end
  end

  // The segment holds the registered read; gating on vld makes the payload
  // zero out of reset, between pops and on empty pops.
  assign rdf_pop_payload  = (pop_vld_q && !pop_empty_q) ? seg_pop_entry[pop_tag_q] : '0;
  assign rdf_pop_vld      = pop_vld_q;
  assign rdf_pop_empty    = pop_empty_q;
  assign rdf_err_ovf      = err_q;
  assign rdf_tag_done     = seg_done;
  assign rdf_tag_cnt      = seg_cnt[rdf_tag_cnt_sel];
  assign rsp_rdf_push_rdy = &seg_room;

endmodule

// File: tb/tb_apb2axi_rdf.sv
module tb_apb2axi_rdf;
  import apb2axi_pkg::*;

  logic                aclk = 1'b0;
  logic                areset = 1'b1;
  logic                rsp_rdf_push_vld = 1'b0;
  rdf_entry_t          rsp_rdf_push_payload = '0;
  logic                rsp_rdf_push_rdy;
  logic                rdf_pop_req = 1'b0;
  logic [TAG_W-1:0]    rdf_pop_tag = '0;
  logic                rdf_pop_vld;
  rdf_entry_t          rdf_pop_payload;
  logic                rdf_pop_empty;
  logic                rdf_flush = 1'b0;
  logic [TAG_W-1:0]    rdf_flush_tag = '0;
  logic [TAG_NUM-1:0]  rdf_tag_done;
  logic [TAG_W-1:0]    rdf_tag_cnt_sel = '0;
  logic [RDF_CNT_W-1:0] rdf_tag_cnt;
  logic                rdf_err_ovf;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  apb2axi_rdf dut (
    .aclk(aclk), .areset(areset),
    .rsp_rdf_push_vld(rsp_rdf_push_vld), .rsp_rdf_push_payload(rsp_rdf_push_payload),
    .rsp_rdf_push_rdy(rsp_rdf_push_rdy),
    .rdf_pop_req(rdf_pop_req), .rdf_pop_tag(rdf_pop_tag),
    .rdf_pop_vld(rdf_pop_vld), .rdf_pop_payload(rdf_pop_payload), .rdf_pop_empty(rdf_pop_empty),
    .rdf_flush(rdf_flush), .rdf_flush_tag(rdf_flush_tag),
    .rdf_tag_done(rdf_tag_done),
    .rdf_tag_cnt_sel(rdf_tag_cnt_sel), .rdf_tag_cnt(rdf_tag_cnt),
    .rdf_err_ovf(rdf_err_ovf)
  );

  // One clock of stimulus; outputs are observed 1 time unit after the edge.
  task automatic cyc(input logic pv, input logic [TAG_W-1:0] pt, input logic [31:0] pd,
                     input logic pl, input logic qv, input logic [TAG_W-1:0] qt,
                     input logic fv, input logic [TAG_W-1:0] ft);
    rsp_rdf_push_vld             = pv;
    rsp_rdf_push_payload.tag     = pt;
    rsp_rdf_push_payload.data    = pd;
    rsp_rdf_push_payload.last    = pl;
    rsp_rdf_push_payload.resp    = 2'b00;
    rdf_pop_req                  = qv;
    rdf_pop_tag                  = qt;
    rdf_flush                    = fv;
    rdf_flush_tag                = ft;
    @(posedge aclk);
    #1;
    rsp_rdf_push_vld = 1'b0;
    rdf_pop_req      = 1'b0;
    rdf_flush        = 1'b0;
  endtask

  task automatic push(input logic [TAG_W-1:0] t, input logic [31:0] d, input logic l);
    cyc(1'b1, t, d, l, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic pop(input logic [TAG_W-1:0] t);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, t, 1'b0, '0);
  endtask

  task automatic test_reset();
    checks++; if (rdf_pop_vld !== 1'b0) begin errors++; $display("FAIL reset_pop_vld got %b exp 0", rdf_pop_vld); end
    checks++; if (rdf_pop_payload !== '0) begin errors++; $display("FAIL reset_payload got %h exp 0", rdf_pop_payload); end
    checks++; if (rdf_pop_empty !== 1'b0) begin errors++; $display("FAIL reset_pop_empty got %b exp 0", rdf_pop_empty); end
    checks++; if (rdf_err_ovf !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", rdf_err_ovf); end
    checks++; if (rdf_tag_done !== 8'h00) begin errors++; $display("FAIL reset_done got %h exp 00", rdf_tag_done); end
    checks++; if (rsp_rdf_push_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", rsp_rdf_push_rdy); end
    rdf_tag_cnt_sel = 3'd3; #1;
    checks++; if (rdf_tag_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", rdf_tag_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_single_tag();
    rdf_tag_cnt_sel = 3'd3;
    for (int i = 0; i < 4; i++) push(3'd3, 32'hA0 + i, i == 3);
    checks++; if (rdf_tag_done !== 8'h08) begin errors++; $display("FAIL single_done_set got %h exp 08", rdf_tag_done); end
    checks++; if (rdf_tag_cnt !== 5'd4) begin errors++; $display("FAIL single_cnt got %0d exp 4", rdf_tag_cnt); end
    for (int i = 0; i < 4; i++) begin
      pop(3'd3);
      checks++; if (rdf_pop_vld !== 1'b1 || rdf_pop_payload.data !== 32'hA0 + i)
        begin errors++; $display("FAIL single_pop%0d got vld=%b data=%h exp vld=1 data=%h", i, rdf_pop_vld, rdf_pop_payload.data, 32'hA0 + i); end
      if (i == 2) begin
        checks++; if (rdf_tag_done[3] !== 1'b1) begin errors++; $display("FAIL single_done_hold got %b exp 1", rdf_tag_done[3]); end
      end
    end
    checks++; if (rdf_tag_done !== 8'h00) begin errors++; $display("FAIL single_done_clr got %h exp 00", rdf_tag_done); end
    cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    checks++; if (rdf_pop_vld !== 1'b0) begin errors++; $display("FAIL single_vld_pulse got %b exp 0", rdf_pop_vld); end
    $display("test_single_tag done");
  endtask

  task automatic test_interleave();
    push(3'd1, 32'h11, 1'b0);
    push(3'd2, 32'h21, 1'b0);
    push(3'd1, 32'h12, 1'b1);
    push(3'd2, 32'h22, 1'b1);
    checks++; if (rdf_tag_done !== 8'b0000_0110) begin errors++; $display("FAIL inter_done got %b exp 00000110", rdf_tag_done); end
    pop(3'd2);
    checks++; if (rdf_pop_payload.data !== 32'h21) begin errors++; $display("FAIL inter_t2a got %h exp 21", rdf_pop_payload.data); end
    pop(3'd1);
    checks++; if (rdf_pop_payload.data !== 32'h11) begin errors++; $display("FAIL inter_t1a got %h exp 11", rdf_pop_payload.data); end
    pop(3'd1);
    checks++; if (rdf_pop_payload.data !== 32'h12 || rdf_pop_payload.tag !== 3'd1)
      begin errors++; $display("FAIL inter_t1b got tag=%0d data=%h exp tag=1 data=12", rdf_pop_payload.tag, rdf_pop_payload.data); end
    pop(3'd2);
    checks++; if (rdf_pop_payload.data !== 32'h22) begin errors++; $display("FAIL inter_t2b got %h exp 22", rdf_pop_payload.data); end
    checks++; if (rdf_tag_done !== 8'h00) begin errors++; $display("FAIL inter_done_clr got %h exp 00", rdf_tag_done); end
    $display("test_interleave done");
  endtask

  task automatic test_empty_pop();
    rdf_tag_cnt_sel = 3'd7;
    pop(3'd7);
    checks++; if (rdf_pop_vld !== 1'b1 || rdf_pop_empty !== 1'b1 || rdf_pop_payload !== '0)
      begin errors++; $display("FAIL empty_pop got vld=%b empty=%b pl=%h exp 1 1 0", rdf_pop_vld, rdf_pop_empty, rdf_pop_payload); end
    cyc(1'b1, 3'd7, 32'h77, 1'b0, 1'b1, 3'd7, 1'b0, '0);
    checks++; if (rdf_pop_empty !== 1'b1 || rdf_pop_payload !== '0)
      begin errors++; $display("FAIL empty_bypass got empty=%b pl=%h exp 1 0", rdf_pop_empty, rdf_pop_payload); end
    checks++; if (rdf_tag_cnt !== 5'd1) begin errors++; $display("FAIL empty_cnt got %0d exp 1", rdf_tag_cnt); end
    pop(3'd7);
    checks++; if (rdf_pop_empty !== 1'b0 || rdf_pop_payload.data !== 32'h77)
      begin errors++; $display("FAIL empty_after got empty=%b data=%h exp 0 77", rdf_pop_empty, rdf_pop_payload.data); end
    $display("test_empty_pop done");
  endtask

  task automatic test_wrap();
    rdf_tag_cnt_sel = 3'd0;
    for (int i = 0; i < 16; i++) push(3'd0, 32'hC0 + i, 1'b0);
    checks++; if (rdf_tag_cnt !== 5'd16) begin errors++; $display("FAIL wrap_cnt16 got %0d exp 16", rdf_tag_cnt); end
    for (int i = 0; i < 16; i++) begin
      pop(3'd0);
      checks++; if (rdf_pop_payload.data !== 32'hC0 + i) begin errors++; $display("FAIL wrap_pop%0d got %h exp %h", i, rdf_pop_payload.data, 32'hC0 + i); end
    end
    for (int i = 0; i < 3; i++) push(3'd0, 32'hD0 + i, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pop(3'd0);
      checks++; if (rdf_pop_payload.data !== 32'hD0 + i) begin errors++; $display("FAIL wrap_post%0d got %h exp %h", i, rdf_pop_payload.data, 32'hD0 + i); end
    end
    checks++; if (rdf_tag_cnt !== 5'd0) begin errors++; $display("FAIL wrap_cnt0 got %0d exp 0", rdf_tag_cnt); end
    $display("test_wrap done");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) push(3'd4, 32'h40 + i, i == 5);
    push(3'd6, 32'h60, 1'b1);
    checks++; if (rdf_tag_done !== 8'h50) begin errors++; $display("FAIL flush_done_pre got %h exp 50", rdf_tag_done); end
    cyc(1'b1, 3'd4, 32'h4F, 1'b0, 1'b0, '0, 1'b1, 3'd4);
    rdf_tag_cnt_sel = 3'd4; #1;
    checks++; if (rdf_tag_cnt !== 5'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", rdf_tag_cnt); end
    checks++; if (rdf_tag_done !== 8'h40) begin errors++; $display("FAIL flush_done got %h exp 40", rdf_tag_done); end
    checks++; if (rdf_err_ovf !== 1'b0) begin errors++; $display("FAIL flush_err got %b exp 0", rdf_err_ovf); end
    rdf_tag_cnt_sel = 3'd6; #1;
    checks++; if (rdf_tag_cnt !== 5'd1) begin errors++; $display("FAIL flush_other got %0d exp 1", rdf_tag_cnt); end
    pop(3'd4);
    checks++; if (rdf_pop_empty !== 1'b1) begin errors++; $display("FAIL flush_pop_empty got %b exp 1", rdf_pop_empty); end
    pop(3'd6);
    checks++; if (rdf_pop_payload.data !== 32'h60) begin errors++; $display("FAIL flush_pop6 got %h exp 60", rdf_pop_payload.data); end
    $display("test_flush done");
  endtask

  task automatic test_full();
    rdf_tag_cnt_sel = 3'd5;
    for (int i = 0; i < 14; i++) push(3'd5, 32'h50 + i, 1'b0);
    checks++; if (rsp_rdf_push_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy14 got %b exp 1", rsp_rdf_push_rdy); end
    push(3'd5, 32'h5E, 1'b0);
    checks++; if (rsp_rdf_push_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy15 got %b exp 0", rsp_rdf_push_rdy); end
    pop(3'd5);
    checks++; if (rdf_pop_payload.data !== 32'h50) begin errors++; $display("FAIL full_pop0 got %h exp 50", rdf_pop_payload.data); end
    checks++; if (rsp_rdf_push_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_back got %b exp 1", rsp_rdf_push_rdy); end
    push(3'd5, 32'h5F, 1'b0);
    push(3'd5, 32'h60, 1'b0);
    checks++; if (rdf_tag_cnt !== 5'd16 || rdf_err_ovf !== 1'b0)
      begin errors++; $display("FAIL full_16 got cnt=%0d err=%b exp 16 0", rdf_tag_cnt, rdf_err_ovf); end
    push(3'd5, 32'h61, 1'b1);
    checks++; if (rdf_tag_cnt !== 5'd16 || rdf_err_ovf !== 1'b1 || rdf_tag_done[5] !== 1'b0)
      begin errors++; $display("FAIL full_drop got cnt=%0d err=%b done=%b exp 16 1 0", rdf_tag_cnt, rdf_err_ovf, rdf_tag_done[5]); end
    for (int i = 0; i < 16; i++) begin
      logic [31:0] exp_d;
      exp_d = (i < 14) ? 32'h51 + i : 32'h5F + (i - 14);
      pop(3'd5);
      checks++; if (rdf_pop_payload.data !== exp_d) begin errors++; $display("FAIL full_drain%0d got %h exp %h", i, rdf_pop_payload.data, exp_d); end
    end
    checks++; if (rdf_err_ovf !== 1'b1) begin errors++; $display("FAIL full_err_sticky got %b exp 1", rdf_err_ovf); end
    $display("test_full done");
  endtask

  task automatic test_reset_mid();
    rdf_tag_cnt_sel = 3'd2;
    push(3'd2, 32'h2A, 1'b0);
    push(3'd2, 32'h2B, 1'b1);
    pop(3'd2);
    checks++; if (rdf_pop_vld !== 1'b1) begin errors++; $display("FAIL mid_pre_vld got %b exp 1", rdf_pop_vld); end
    #1 areset = 1'b1;
    #1;
    checks++; if (rdf_pop_vld !== 1'b0 || rdf_pop_payload !== '0 || rdf_pop_empty !== 1'b0)
      begin errors++; $display("FAIL mid_pop got vld=%b pl=%h empty=%b exp 0 0 0", rdf_pop_vld, rdf_pop_payload, rdf_pop_empty); end
    checks++; if (rdf_tag_cnt !== 5'd0 || rdf_tag_done !== 8'h00 || rdf_err_ovf !== 1'b0 || rsp_rdf_push_rdy !== 1'b1)
      begin errors++; $display("FAIL mid_state got cnt=%0d done=%h err=%b rdy=%b exp 0 00 0 1", rdf_tag_cnt, rdf_tag_done, rdf_err_ovf, rsp_rdf_push_rdy); end
    @(negedge aclk); areset = 1'b0;
    pop(3'd2);
    checks++; if (rdf_pop_empty !== 1'b1) begin errors++; $display("FAIL mid_after_empty got %b exp 1", rdf_pop_empty); end
    $display("test_reset_mid done");
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    test_reset();
    test_single_tag();
    test_interleave();
    test_empty_pop();
    test_wrap();
    test_flush();
    test_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
